// File: rtl/clk_sched_pkg.sv
// ---------------------------------------------------------------------------
// clk_sched_pkg
// Shared types and constants for the clock-enable scheduler.
//   DEF_NUM_CH  : default number of enable channels
//   DEF_CNT_W   : default counter/divisor width
//   DEFAULT_DIV : divisor every channel holds after reset (0 = disabled)
//   cnt_t/div_t : counter and divisor words at the default width
//   cfg_req_t   : one configuration request {chan, div}
//   chan_width(): channel-select width, never narrower than one bit
// ---------------------------------------------------------------------------
package clk_sched_pkg;

  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_CNT_W   = 16;
  localparam int DEFAULT_DIV = 2;

  // $clog2(1) is 0, which would give a zero-width select for a single channel.
  function automatic int chan_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_CHAN_W = chan_width(DEF_NUM_CH);

  typedef logic [DEF_CNT_W-1:0]  cnt_t;
  typedef logic [DEF_CNT_W-1:0]  div_t;
  typedef logic [DEF_CHAN_W-1:0] chan_t;

  typedef struct packed {
    chan_t chan;
    div_t  div;
  } cfg_req_t;

endpackage

// File: rtl/clk_enable_scheduler_if.sv
// ---------------------------------------------------------------------------
// clk_enable_scheduler_if
// Configuration handshake plus enable outputs of the scheduler.
//   cfg_valid/cfg_ready : request handshake, accepted when both are high
//   cfg_chan/cfg_div    : target channel and new divisor (0 disables)
//   sync                : realign every channel counter to 0
//   tick                : per-channel single-cycle enables
//   cfg_pending         : an accepted update is waiting for its wrap
//   clk_div             : per-channel toggle outputs (0 unless
//                         CLK_SCHED_TOGGLE_OUT_EN is defined)
// master = requester / consumer side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface clk_enable_scheduler_if #(
  parameter int NUM_CH = clk_sched_pkg::DEF_NUM_CH,
  parameter int CNT_W  = clk_sched_pkg::DEF_CNT_W
);
  localparam int CH_W = clk_sched_pkg::chan_width(NUM_CH);

  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_chan;
  logic [CNT_W-1:0]  cfg_div;
  logic              sync;
  logic [NUM_CH-1:0] tick;
  logic              cfg_pending;
  logic [NUM_CH-1:0] clk_div;

  modport master (
    output cfg_valid, cfg_chan, cfg_div, sync,
    input  cfg_ready, tick, cfg_pending, clk_div
  );

  modport slave (
    input  cfg_valid, cfg_chan, cfg_div, sync,
    output cfg_ready, tick, cfg_pending, clk_div
  );
endinterface

// File: rtl/clk_sched_channel.sv
// ---------------------------------------------------------------------------
// clk_sched_channel
// One clock-enable generator: a counter running 0..div-1 and a divisor reg.
//   clk, rst    : root clock, synchronous active-high reset
//   sel_i       : the pending update targets this channel
//   sync_i      : realign the counter to 0
//   new_div_i   : divisor to load when the update is applied
//   tick_o      : single-cycle enable, decoded from registered state only
//   clk_div_o   : toggle output (register only with CLK_SCHED_TOGGLE_OUT_EN)
//   applied_o   : the pending update is being applied at this edge
// ---------------------------------------------------------------------------
module clk_sched_channel #(
  parameter int CNT_W       = clk_sched_pkg::DEF_CNT_W,
  parameter int DEFAULT_DIV = clk_sched_pkg::DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel_i,
  input  logic             sync_i,
  input  logic [CNT_W-1:0] new_div_i,
  output logic             tick_o,
  output logic             clk_div_o,
  output logic             applied_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             quiet_q;
  logic             idle;
  logic             wrap;
  logic             apply;

  assign idle = (div_q == '0);
  assign wrap = !idle && (cnt_q == div_q - CNT_W'(1));

  // Updates land only on a period boundary (wrap), on a disabled channel, or
  // together with a sync, so no truncated or stretched period can appear.
  // The boundary is the raw wrap, so a div=1 channel still takes an update in
  // the quiet cycle after a sync.
  assign apply     = sel_i && (wrap || idle || sync_i);
  assign applied_o = apply;

  // quiet_q blanks the cycle after reset or sync; it only matters for div=1,
  // whose counter sits on its wrap value permanently.
  assign tick_o = wrap && !quiet_q;

  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    if (apply) begin
      div_d = new_div_i;
      cnt_d = '0;
    end else if (sync_i || idle || wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      div_q   <= CNT_W'(DEFAULT_DIV);
      quiet_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      quiet_q <= sync_i;
    end
  end

`ifdef CLK_SCHED_TOGGLE_OUT_EN
  logic clk_div_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_div_q <= 1'b0;
    end else if (tick_o) begin
      clk_div_q <= ~clk_div_q;
    end
  end

  assign clk_div_o = clk_div_q;
`else
  assign clk_div_o = 1'b0;
`endif

endmodule

// File: rtl/clk_enable_scheduler.sv
// ---------------------------------------------------------------------------
// clk_enable_scheduler
// Runtime-programmable bank of NUM_CH clock-enable generators on one clock.
// Consumers stay on clk and qualify their logic with tick[i].
//   clk, rst : root clock, synchronous active-high reset
//   bus      : clk_enable_scheduler_if.slave (cfg handshake, sync, tick,
//              cfg_pending, clk_div)
// A single pending slot holds an accepted {chan, div}; it is handed to the
// target channel, which applies it at its next wrap (or at once when the
// channel is disabled or sync is high). Requests for channels >= NUM_CH
// complete the handshake and are dropped.
// Optional: define CLK_SCHED_TOGGLE_OUT_EN for square-wave clk_div outputs.
// ---------------------------------------------------------------------------
module clk_enable_scheduler #(
  parameter int NUM_CH      = clk_sched_pkg::DEF_NUM_CH,
  parameter int CNT_W       = clk_sched_pkg::DEF_CNT_W,
  parameter int DEFAULT_DIV = clk_sched_pkg::DEFAULT_DIV
) (
  input  logic                   clk,
  input  logic                   rst,
  clk_enable_scheduler_if.slave  bus
);
  import clk_sched_pkg::*;

  localparam int CH_W = chan_width(NUM_CH);

  logic              pend_valid_q, pend_valid_d;
  logic [CH_W-1:0]   pend_chan_q, pend_chan_d;
  logic [CNT_W-1:0]  pend_div_q, pend_div_d;
  logic              accept;
  logic              chan_ok;
  logic [NUM_CH-1:0] sel;
  logic [NUM_CH-1:0] applied;
  logic [NUM_CH-1:0] tick_w;
  logic [NUM_CH-1:0] clk_div_w;

  assign bus.cfg_ready   = !pend_valid_q;
  assign bus.cfg_pending = pend_valid_q;
  assign bus.tick        = tick_w;
  assign bus.clk_div     = clk_div_w;

  assign accept  = bus.cfg_valid && !pend_valid_q;
  assign chan_ok = int'(bus.cfg_chan) < NUM_CH;

  // Accept and apply are mutually exclusive: accept needs an empty slot,
  // apply needs a full one.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_chan_d  = pend_chan_q;
    pend_div_d   = pend_div_q;
    if (|applied) begin
      pend_valid_d = 1'b0;
    end else if (accept && chan_ok) begin
      pend_valid_d = 1'b1;
      pend_chan_d  = bus.cfg_chan;
      pend_div_d   = bus.cfg_div;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid_q <= 1'b0;
      pend_chan_q  <= '0;
      pend_div_q   <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_chan_q  <= pend_chan_d;
      pend_div_q   <= pend_div_d;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign sel[gi] = pend_valid_q && (int'(pend_chan_q) == gi);

    clk_sched_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .sel_i     (sel[gi]),
      .sync_i    (bus.sync),
      .new_div_i (pend_div_q),
      .tick_o    (tick_w[gi]),
      .clk_div_o (clk_div_w[gi]),
      .applied_o (applied[gi])
    );
  end

endmodule
